rr_arb_mux: RTL and testbench
=============================

Name: rr_arb_mux

Overview:
- Round-robin arbiter and output register that shares one N-way datapath mux between NUM_REQ requesters.
- Picks one active requester per transfer, routes its data word through the mux into a 1-deep output register, and presents it downstream with a valid/ready handshake.
- Sits in front of any single-consumer datapath that must be fed from several sources.

Parameters:
- NUM_REQ, 4, number of requesters (≥2).
- DATA_W, 8, data word width in bits.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- req_i  input  NUM_REQ  request vector, one bit per requester.
- data_i  input  NUM_REQ*DATA_W  packed words; requester k occupies bits [k*DATA_W +: DATA_W].
- gnt_o  output  NUM_REQ  one-hot grant (combinational); high in the cycle the word is captured.
- y_valid_o  output  1  output register holds a word.
- y_o  output  DATA_W  output data word (registered).
- y_ready_i  input  1  downstream accepts y_o this cycle.

Behaviour:
- Reset (asynchronous, takes effect immediately): y_valid_o=0, y_o=0, ptr=0, state=EMPTY. While reset is high, gnt_o=0.
- State machine:
  - EMPTY (y_valid_o=0) and FULL (y_valid_o=1).
  - load = |req_i && (state==EMPTY || y_ready_i).
  - EMPTY: load -> FULL; otherwise stay in EMPTY.
  - FULL: if y_ready_i && !load -> EMPTY. If load -> FULL, with the new word replacing the old one in the same edge (back-to-back). If !y_ready_i -> stay in FULL; y_o, y_valid_o and ptr are held.
- Arbitration:
  - winner = first index with req_i set, scanning ptr, ptr+1, … NUM_REQ-1, 0, … ptr-1 (circular).
  - gnt_o = load ? onehot(winner) : 0.
  - On load: y_o <= data_i[winner]; y_valid_o <= 1; ptr <= (winner+1) mod NUM_REQ.
  - When not loading, ptr is unchanged.
- Requester contract:
  - Hold req_i and data_i stable until gnt_o[k] is seen.
  - The word is consumed at that edge. Keeping req_i high afterwards requests another transfer.
- Latency and throughput:
  - Grant to y_valid_o: 1 cycle.
  - Peak rate: one word per cycle with y_ready_i held high.
- Fairness: every continuously requesting source is granted within NUM_REQ transfers.
- Boundary conditions:
  - req_i=0: gnt_o=0; a FULL register drains on y_ready_i.
  - y_ready_i=1 while EMPTY: ignored.
  - ptr wraps from NUM_REQ-1 to 0.
  - Reset mid-transfer: the held word is discarded, no grant is issued, and ptr returns to 0.

Optional Feature:
- Macro: RR_ARB_MUX_LOCK_EN.
- Defined:
  - Adds input lock_i [NUM_REQ].
  - If winner w was granted with lock_i[w]=1, a locked flag is set with owner=w.
  - While locked, only req_i[w] can win and ptr is not advanced.
  - The lock releases on the first grant to w with lock_i[w]=0, or when req_i[w] drops. Arbitration then resumes from (w+1) mod NUM_REQ.
  - Reset clears the lock.
- Undefined: no lock_i port and no lock state; pure round-robin.

Decomposition:
- Package rr_arb_mux_pkg:
  - State enum typedef (EMPTY, FULL).
  - Default NUM_REQ and DATA_W localparams.
  - Function onehot(index).
- Sub-module rr_pick:
  - Purely combinational.
  - Inputs: req vector and ptr. Outputs: winner index, any-request flag.
  - Reused by the lock path with a masked request vector.

Test Plan (NUM_REQ=4, DATA_W=8):
- After reset, req_i=4'b0010, data_i[1]=8'hA5, y_ready_i=1 -> gnt_o=4'b0010 in the same cycle; next cycle y_valid_o=1, y_o=8'hA5.
- req_i=4'b1111, data_i[k]=8'h10+k, y_ready_i=1 for 5 cycles -> gnt_o sequence 0001, 0010, 0100, 1000, 0001; y_o sequence 10, 11, 12, 13, 10, back-to-back with no bubble.
- FULL with y_o=8'h11, req_i=4'b1111, y_ready_i=0 for 3 cycles -> gnt_o=0 and y_o holds 8'h11. Raise y_ready_i -> gnt_o=4'b0100 in that cycle; y_o=8'h12 on the next edge.
- Wrap-around: ptr=3 (after granting index 2), req_i=4'b0101 -> gnt_o=4'b0001; ptr becomes 1.
- FULL with y_o=8'h5A, assert reset mid-cycle -> y_valid_o=0 and y_o=0 immediately. After release, req_i=4'b1111 -> first grant is 4'b0001.
- Lock (RR_ARB_MUX_LOCK_EN), req_i=4'b1111:
  - Set lock_i=4'b0010, then grant index 1 -> the next 3 grants are all 4'b0010.
  - Clear lock_i[1] -> index 1 gets one final grant, then the next grant is 4'b0100.

Source files
------------

// File: rtl/rr_arb_mux_pkg.sv
// Shared types and helpers for the round-robin arbiter/mux.
package rr_arb_mux_pkg;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_e;

    localparam int NUM_REQ_DEF = 4;
    localparam int DATA_W_DEF  = 8;

    // Callers slice the low NUM_REQ bits; supports up to 32 requesters.
    function automatic logic [31:0] onehot(input logic [31:0] idx);
        onehot = 32'd1 << idx;
    endfunction

endpackage

// File: rtl/rr_arb_mux_pick.sv
// Combinational circular priority pick: first set request at or after ptr_i.
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [PTR_W-1:0]   ptr_i,
    output logic [PTR_W-1:0]   winner_o,
    output logic               any_o
);

    always_comb begin
        logic [31:0]      pos;
        logic [PTR_W-1:0] idx;
        winner_o = '0;
        any_o    = 1'b0;
        pos      = '0;
        idx      = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            pos = (32'(ptr_i) + 32'(i)) % NUM_REQ;
            idx = PTR_W'(pos);
            if (req_i[idx] && !any_o) begin
                winner_o = idx;
                any_o    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_arb_mux.sv
// Round-robin arbiter feeding a shared mux into a 1-deep valid/ready output register.
// Optional grant locking enabled by defining RR_ARB_MUX_LOCK_EN (adds lock_i).
module rr_arb_mux
    import rr_arb_mux_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int DATA_W  = DATA_W_DEF
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_i,
    input  logic [NUM_REQ*DATA_W-1:0] data_i,
`ifdef RR_ARB_MUX_LOCK_EN
    input  logic [NUM_REQ-1:0]        lock_i,
`endif
    output logic [NUM_REQ-1:0]        gnt_o,
    output logic                      y_valid_o,
    output logic [DATA_W-1:0]         y_o,
    input  logic                      y_ready_i
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    state_e                           state_q, state_d;
    logic [PTR_W-1:0]                 ptr_q, ptr_d;
    logic [DATA_W-1:0]                y_q, y_d;
    logic [NUM_REQ-1:0][DATA_W-1:0]   words;
    logic [NUM_REQ-1:0]               pick_req;
    logic [PTR_W-1:0]                 winner;
    logic                             any_req;
    logic                             load;

    assign words = data_i;

`ifdef RR_ARB_MUX_LOCK_EN
    logic             locked_q, locked_d;
    logic [PTR_W-1:0] owner_q, owner_d;
    logic             hold_lock;

    // A lock only survives while its owner keeps requesting.
    assign hold_lock = locked_q && req_i[owner_q];
    assign pick_req  = hold_lock ? (req_i & NUM_REQ'(onehot(32'(owner_q)))) : req_i;
`else
    assign pick_req  = req_i;
`endif

    rr_pick #(.NUM_REQ(NUM_REQ), .PTR_W(PTR_W)) u_pick (
        .req_i    (pick_req),
        .ptr_i    (ptr_q),
        .winner_o (winner),
        .any_o    (any_req)
    );

    assign load      = any_req && (state_q == EMPTY || y_ready_i) && !reset;
    assign gnt_o     = load ? NUM_REQ'(onehot(32'(winner))) : '0;
    assign y_valid_o = (state_q == FULL);
    assign y_o       = y_q;

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        y_d      = y_q;
`ifdef RR_ARB_MUX_LOCK_EN
        locked_d = hold_lock;
        owner_d  = owner_q;
`endif
        if (load) begin
            state_d = FULL;
            y_d     = words[winner];
            // While locked winner==owner, so ptr stays at owner+1.
            ptr_d   = (winner == PTR_W'(NUM_REQ - 1)) ? '0 : winner + PTR_W'(1);
`ifdef RR_ARB_MUX_LOCK_EN
            locked_d = lock_i[winner];
            owner_d  = winner;
`endif
        end else if (state_q == FULL && y_ready_i) begin
            state_d = EMPTY;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= EMPTY;
            ptr_q   <= '0;
            y_q     <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            y_q     <= y_d;
        end
    end

`ifdef RR_ARB_MUX_LOCK_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            locked_q <= 1'b0;
            owner_q  <= '0;
        end else begin
            locked_q <= locked_d;
            owner_q  <= owner_d;
        end
    end
`endif

endmodule

// File: tb/tb_rr_arb_mux.sv
// Self-checking bench for rr_arb_mux: directed scenarios plus randomized traffic vs a queue-free model.
module tb_rr_arb_mux;

    localparam int N = 4;
    localparam int W = 8;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic [N-1:0]   req_i = '0;
    logic [N-1:0]   lock = '0;
    logic [N*W-1:0] data_i = '0;
    logic           y_ready_i = 1'b0;
    logic [N-1:0]   gnt_o;
    logic           y_valid_o;
    logic [W-1:0]   y_o;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    bit           m_valid;
    logic [W-1:0] m_y;
    int           m_ptr;
    bit           m_locked;
    int           m_owner;

    always #5 clk = ~clk;

    rr_arb_mux #(.NUM_REQ(N), .DATA_W(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_i     (req_i),
        .data_i    (data_i),
`ifdef RR_ARB_MUX_LOCK_EN
        .lock_i    (lock),
`endif
        .gnt_o     (gnt_o),
        .y_valid_o (y_valid_o),
        .y_o       (y_o),
        .y_ready_i (y_ready_i)
    );

    function automatic void model_reset();
        m_valid  = 0;
        m_y      = '0;
        m_ptr    = 0;
        m_locked = 0;
        m_owner  = 0;
    endfunction

    function automatic int m_winner(input logic [N-1:0] r);
`ifdef RR_ARB_MUX_LOCK_EN
        if (m_locked && r[m_owner]) return m_owner;
`endif
        for (int i = 0; i < N; i++)
            if (r[(m_ptr + i) % N]) return (m_ptr + i) % N;
        return -1;
    endfunction

    // Drive one cycle, sample the grant before the edge, advance the model across the edge.
    task automatic apply(input logic [N-1:0] r, input logic [N*W-1:0] d, input logic rdy,
                         output logic [N-1:0] g_obs, output logic [N-1:0] g_exp);
        int w;
        req_i = r; data_i = d; y_ready_i = rdy;
        #1;
        g_obs = gnt_o;
        w = m_winner(r);
        g_exp = '0;
        if (w >= 0 && (!m_valid || rdy)) g_exp[w] = 1'b1;
        @(posedge clk);
        if (g_exp != '0) begin
            m_y = d[w*W +: W];
            m_valid = 1;
            m_ptr = (w + 1) % N;
`ifdef RR_ARB_MUX_LOCK_EN
            m_locked = lock[w];
            m_owner = w;
`endif
        end else begin
            if (rdy) m_valid = 0;
`ifdef RR_ARB_MUX_LOCK_EN
            if (m_locked && !r[m_owner]) m_locked = 0;
`endif
        end
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; req_i = '0; y_ready_i = 1'b0; lock = '0;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        reset = 1'b1; req_i = 4'b1111; y_ready_i = 1'b1;
        @(negedge clk); #1;
        n_vec++; if (gnt_o !== 4'b0000) begin n_err++; $display("FAIL reset_gnt got=%b want=0000", gnt_o); end
        n_vec++; if (y_valid_o !== 1'b0) begin n_err++; $display("FAIL reset_valid got=%b want=0", y_valid_o); end
        n_vec++; if (y_o !== 8'h00) begin n_err++; $display("FAIL reset_y got=%h want=00", y_o); end
        do_reset();
    endtask

    task automatic test_single();
        logic [N-1:0] go, ge;
        apply(4'b0010, 32'h0000A500, 1'b1, go, ge);
        n_vec++; if (go !== 4'b0010) begin n_err++; $display("FAIL single_gnt got=%b want=0010", go); end
        n_vec++; if (y_valid_o !== 1'b1 || y_o !== 8'hA5) begin n_err++; $display("FAIL single_y got=%b/%h want=1/a5", y_valid_o, y_o); end
        apply(4'b0000, 32'h0, 1'b1, go, ge);
        n_vec++; if (go !== 4'b0000 || y_valid_o !== 1'b0) begin n_err++; $display("FAIL drain got=%b/%b want=0000/0", go, y_valid_o); end
        apply(4'b0000, 32'h0, 1'b1, go, ge);
        n_vec++; if (go !== 4'b0000 || y_valid_o !== 1'b0) begin n_err++; $display("FAIL empty_ready got=%b/%b want=0000/0", go, y_valid_o); end
    endtask

    task automatic test_rr_sequence();
        logic [N-1:0] go, ge;
        logic [N-1:0] g_tab [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        logic [W-1:0] y_tab [5] = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            apply(4'b1111, 32'h13121110, 1'b1, go, ge);
            n_vec++; if (go !== g_tab[i]) begin n_err++; $display("FAIL rr_gnt[%0d] got=%b want=%b", i, go, g_tab[i]); end
            n_vec++; if (y_valid_o !== 1'b1 || y_o !== y_tab[i]) begin n_err++; $display("FAIL rr_y[%0d] got=%b/%h want=1/%h", i, y_valid_o, y_o, y_tab[i]); end
        end
    endtask

    task automatic test_backpressure_and_wrap();
        logic [N-1:0] go, ge;
        do_reset();
        apply(4'b1111, 32'h13121110, 1'b1, go, ge);
        apply(4'b1111, 32'h13121110, 1'b1, go, ge);
        for (int i = 0; i < 3; i++) begin
            apply(4'b1111, 32'h13121110, 1'b0, go, ge);
            n_vec++; if (go !== 4'b0000 || y_o !== 8'h11 || y_valid_o !== 1'b1) begin n_err++; $display("FAIL stall[%0d] got=%b/%h want=0000/11", i, go, y_o); end
        end
        apply(4'b1111, 32'h13121110, 1'b1, go, ge);
        n_vec++; if (go !== 4'b0100 || y_o !== 8'h12) begin n_err++; $display("FAIL unstall got=%b/%h want=0100/12", go, y_o); end
        apply(4'b0101, 32'h13121110, 1'b1, go, ge);
        n_vec++; if (go !== 4'b0001 || y_o !== 8'h10) begin n_err++; $display("FAIL wrap got=%b/%h want=0001/10", go, y_o); end
        apply(4'b0101, 32'h13121110, 1'b1, go, ge);
        n_vec++; if (go !== 4'b0100 || y_o !== 8'h12) begin n_err++; $display("FAIL wrap_ptr got=%b/%h want=0100/12", go, y_o); end
    endtask

    task automatic test_reset_mid();
        logic [N-1:0] go, ge;
        do_reset();
        apply(4'b0001, 32'h0000005A, 1'b0, go, ge);
        n_vec++; if (y_o !== 8'h5A || y_valid_o !== 1'b1) begin n_err++; $display("FAIL mid_load got=%b/%h want=1/5a", y_valid_o, y_o); end
        req_i = 4'b1111; y_ready_i = 1'b1;
        #2 reset = 1'b1;
        #1;
        n_vec++; if (y_valid_o !== 1'b0 || y_o !== 8'h00 || gnt_o !== 4'b0000) begin n_err++; $display("FAIL mid_reset got=%b/%h/%b want=0/00/0000", y_valid_o, y_o, gnt_o); end
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        apply(4'b1111, 32'h13121110, 1'b1, go, ge);
        n_vec++; if (go !== 4'b0001) begin n_err++; $display("FAIL post_reset got=%b want=0001", go); end
    endtask

`ifdef RR_ARB_MUX_LOCK_EN
    task automatic test_lock();
        logic [N-1:0] go, ge;
        logic [N-1:0] g_tab [7] = '{4'b0001, 4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0100};
        do_reset();
        for (int i = 0; i < 7; i++) begin
            lock = (i < 5) ? 4'b0010 : 4'b0000;
            apply(4'b1111, 32'h13121110, 1'b1, go, ge);
            n_vec++; if (go !== g_tab[i]) begin n_err++; $display("FAIL lock[%0d] got=%b want=%b", i, go, g_tab[i]); end
        end
        lock = '0;
    endtask
`endif

    task automatic test_random();
        logic [N-1:0]   go, ge, r, last_g;
        logic [N*W-1:0] d;
        do_reset();
        r = '0; d = '0; last_g = '0;
        for (int c = 0; c < 400; c++) begin
            for (int k = 0; k < N; k++) begin
                if (!r[k] || last_g[k]) begin
                    r[k] = ($urandom_range(0, 2) != 0);
                    d[k*W +: W] = W'($urandom);
                end
            end
`ifdef RR_ARB_MUX_LOCK_EN
            for (int k = 0; k < N; k++) lock[k] = ($urandom_range(0, 3) == 0);
`endif
            apply(r, d, ($urandom_range(0, 3) != 0), go, ge);
            last_g = go;
            n_vec++; if (go !== ge) begin n_err++; $display("FAIL rand_gnt[%0d] got=%b want=%b", c, go, ge); end
            n_vec++; if (y_valid_o !== m_valid || (m_valid && y_o !== m_y)) begin
                n_err++; $display("FAIL rand_y[%0d] got=%b/%h want=%b/%h", c, y_valid_o, y_o, m_valid, m_y);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single();
        test_rr_sequence();
        test_backpressure_and_wrap();
        test_reset_mid();
`ifdef RR_ARB_MUX_LOCK_EN
        test_lock();
`endif
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
